// File: rtl/rx_crc_check.sv
// Receive-side CRC checker for a 32-bit link: decodes comma/check command sequences
// from the K-flag history, runs a CRC-32 over data words and scores check words.

// CRC-32 (poly 0x04C11DB7, MSB-first, init all-ones, no final xor) over one
// 32-bit word per enabled cycle. crc_out is the register, so it reflects every
// word accumulated before the current cycle.
module crc_ol (
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] INIT = 32'hFFFF_FFFF;

  logic [31:0] crc_q;

  // The data word is exactly as wide as the CRC, so it can be folded in up
  // front and then divided out with 32 feedback shifts.
  function automatic logic [31:0] crc_next(input logic [31:0] crc,
                                           input logic [31:0] data);
    logic [31:0] c;
    c = crc ^ data;
    for (int i = 0; i < 32; i++) begin
      c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  // NOTE: this register deliberately has no rst_n term; it is a datapath value
  // that only a decoded CRC reset command may clear, and lock gating hides
  // whatever it holds until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= INIT;
    end else if (crc_en) begin
      crc_q <= crc_next(crc_q, data_in);
    end
  end

  assign crc_out = crc_q;

endmodule

module rx_crc_check #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      d,
  input  logic [3:0]       k,
  input  logic             clr,
  output logic [31:0]      dout,
  output logic [3:0]       kout,
  output logic             crc_word,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             err_sticky,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt
);

  localparam logic [3:0]       K_PAD   = 4'hF;
  localparam logic [3:0]       K_DATA  = 4'h0;
  localparam logic [3:0]       K_COMMA = 4'h1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t      state;
  logic        h1;
  logic        h2;
  logic        is_pad;
  logic        is_check;
  logic        is_crc_rst;
  logic        is_accum;
  logic        crc_match;
  logic        count_chk;
  logic        count_err;
  logic [31:0] crc_val;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    is_pad     = 1'b0;
    is_check   = 1'b0;
    is_crc_rst = 1'b0;
    is_accum   = 1'b0;
    if (k == K_PAD) begin
      is_pad = 1'b1;
    end else if (k == K_DATA && h1 && !h2) begin
      is_check = 1'b1;
    end else if (k == K_COMMA && h1 && h2) begin
      is_crc_rst = 1'b1;
    end else if (k == K_DATA) begin
      is_accum = 1'b1;
    end
  end

  crc_ol u_crc (
    .clk     (clk),
    .rst     (is_crc_rst),
    .crc_en  (is_accum),
    .data_in (d),
    .crc_out (crc_val)
  );

  // Scoring is gated by the lock state in the check cycle: before the first
  // CRC reset the engine content is meaningless.
  assign crc_match = (d == crc_val);
  assign count_chk = is_check && (state == LOCKED);
  assign count_err = count_chk && !crc_match;
  assign locked    = (state == LOCKED);

  // A clear coincident with an event leaves exactly that event counted.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             do_clr);
    if (do_clr) begin
      return inc ? CNT_ONE : '0;
    end else if (inc && cnt != CNT_MAX) begin
      return cnt + CNT_ONE;
    end
    return cnt;
  endfunction

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNLOCKED;
      h1         <= 1'b0;
      h2         <= 1'b0;
      dout       <= '0;
      kout       <= '0;
      crc_word   <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      chk_cnt    <= '0;
    end else begin
      case (state)
        UNLOCKED: if (is_crc_rst) state <= LOCKED;
        LOCKED:   state <= LOCKED;
        default:  state <= UNLOCKED;
      endcase

      if (!is_pad) begin
        h2 <= h1;
        h1 <= k[0];
      end

      dout     <= d;
      kout     <= k;
      crc_word <= is_check;
      crc_ok   <= count_chk && crc_match;
      crc_err  <= count_err;

      if (count_err) begin
        err_sticky <= 1'b1;
      end else if (clr) begin
        err_sticky <= 1'b0;
      end

      chk_cnt <= cnt_next(chk_cnt, count_chk, clr);
      err_cnt <= cnt_next(err_cnt, count_err, clr);
    end
  end

endmodule

// File: doc/rx_crc_check.md
RX_CRC_CHECK -- requirements
Module: rx_crc_check

Interface
REQ-001 Parameter CNT_W, default 16: width of the error and check counters.
REQ-002 clk  input  1  Single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 d  input  32  Received link data word.
REQ-005 k  input  4  Received K-flags for d; 4'hF = padding, 4'h0 = data, other values = comma/control.
REQ-006 clr  input  1  Synchronous clear of counters and sticky error.
REQ-007 dout  output  32  d delayed by one cycle.
REQ-008 kout  output  4  k delayed by one cycle.
REQ-009 crc_word  output  1  High for one cycle when dout is a CRC check word.
REQ-010 crc_ok  output  1  One-cycle pulse when the check word matches.
REQ-011 crc_err  output  1  One-cycle pulse when the check word mismatches.
REQ-012 err_sticky  output  1  Set by any crc_err and held until clr.
REQ-013 locked  output  1  High once a CRC reset command has been received since rst_n.
REQ-014 err_cnt  output  CNT_W  Saturating count of mismatches.
REQ-015 chk_cnt  output  CNT_W  Saturating count of checks performed while locked.

Function
REQ-016 The block SHALL keep a two-deep K history (h1 = newest, h2 = older), updated only for non-padding words: h2<=h1, h1<=k[0].
REQ-017 Command decode SHALL be combinational on the current word, evaluated in priority order:
  - k==4'hF: padding; no CRC action; history unchanged.
  - k==4'h0 with h1=1 and h2=0: CHECK.
  - k==4'h1 with h1=1 and h2=1: CRC RESET.
  - k==4'h0 otherwise: ACCUMULATE.
  - any other k: no action.
REQ-018 The CRC engine SHALL be an instance of crc_ol, with data_in=d, crc_en=ACCUMULATE, rst=CRC RESET, and clk=clk; crc_out reflects every word accumulated before the current cycle.
REQ-019 On CHECK, the block SHALL compare d against crc_out in the same cycle.
REQ-020 The CHECK word SHALL NOT be accumulated into the CRC.
REQ-021 The FSM SHALL have two states:
  - UNLOCKED: reset state.
  - LOCKED: entered on the cycle after the first CRC RESET.
  - The only exit from LOCKED is rst_n; further CRC RESETs keep the FSM in LOCKED.
REQ-022 locked SHALL be high exactly when the FSM is in LOCKED.
REQ-023 crc_word SHALL assert one cycle after any CHECK, regardless of lock state.
REQ-024 crc_ok and crc_err SHALL assert one cycle after a CHECK, and only if the FSM is LOCKED in the CHECK cycle; they are mutually exclusive.
REQ-025 A CHECK while UNLOCKED SHALL produce no crc_ok, no crc_err, and no counter change.
REQ-026 chk_cnt SHALL increment on each locked CHECK, and err_cnt SHALL increment on each mismatch; both saturate at all-ones.
REQ-027 When clr and a counted event occur in the same cycle, the counter SHALL become 1.
REQ-028 When clr and a mismatch occur in the same cycle, err_sticky SHALL become 1.
REQ-029 When clr is asserted with no event, err_cnt, chk_cnt and err_sticky SHALL become 0.
REQ-030 A CRC RESET and CHECK cannot coincide; padding between the comma and the check word SHALL NOT break CHECK detection.
REQ-031 dout, kout, crc_word, crc_ok and crc_err SHALL all be registered with a fixed latency of 1 cycle.

Reset
REQ-032 While rst_n is low, the following SHALL be 0: every output, h1, h2, and the counters; the FSM SHALL be UNLOCKED.
REQ-033 The crc_ol instance SHALL be cleared only by CRC RESET; when rst_n deasserts, CRC content is undefined until the first CRC RESET, which the lock gating covers.
REQ-034 An rst_n assertion mid-frame SHALL abort the frame immediately; the next check is scored only after a new CRC RESET.

Verification
REQ-035 Pulse rst_n low for 3 cycles -> all outputs 0 and locked=0; after release, with k=4'h1 idle, locked is still 0 until the third consecutive comma.
REQ-036 Send 3 words of k=1, then data 0x00000001..0x00000008 (k=0), then 1 comma, then a check word equal to the crc_ol model value -> locked=1, crc_ok pulses exactly 1 cycle after the check word, chk_cnt=1, err_cnt=0.
REQ-037 Repeat REQ-036 with bit 0 of the check word flipped -> crc_err pulses once, err_cnt=1, err_sticky=1; after clr for 1 cycle, all three read 0.
REQ-038 Repeat REQ-036 with two k=4'hF words between the comma and the check word, and one k=4'hF word mid-data -> crc_ok still pulses, and the padding does not change the CRC.
REQ-039 Send a check pattern before any CRC RESET -> crc_word=1, crc_ok=0, crc_err=0, and counters unchanged.
REQ-040 Preload err_cnt to all-ones via repeated errors with CNT_W=4 -> it stays at 4'hF on the next error; clr coincident with an error -> err_cnt=1.
